// File: rtl/mystery_pkg.sv
// Shared types and word transforms for the Mystery2 scrambler/decoder pair.
package mystery_pkg;

   typedef enum logic [1:0] {
      SEED_HI = 2'd0,
      SEED_LO = 2'd1,
      BYTE_A  = 2'd2,
      BYTE_B  = 2'd3
   } tag_e;

   typedef enum logic {
      HUNT  = 1'b0,
      TRACK = 1'b1
   } dec_state_e;

   // FIFO entry layout: {tag[1:0], byte[7:0]}
   localparam int ENTRY_W = 10;

   function automatic logic [15:0] swap_bytes(input logic [15:0] w);
      return {w[7:0], w[15:8]};
   endfunction

   function automatic logic [15:0] nibble_rev(input logic [15:0] w);
      return {w[3:0], w[7:4], w[11:8], w[15:12]};
   endfunction

endpackage

// File: rtl/mystery_byte_fifo.sv
// First-word fall-through FIFO of tagged bytes; accepts up to two writes and
// one read per cycle and reports its free slot count.
module mystery_byte_fifo
   import mystery_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [1:0]                 push_cnt_i,
   input  logic [ENTRY_W-1:0]         push_data0_i,
   input  logic [ENTRY_W-1:0]         push_data1_i,
   input  logic                       pop_i,
   output logic                       out_valid_o,
   output logic [ENTRY_W-1:0]         out_data_o,
   output logic [$clog2(DEPTH):0]     free_o
);

   localparam int AW = $clog2(DEPTH);

   logic [ENTRY_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]      wr_ptr_q;
   logic [AW-1:0]      rd_ptr_q;
   logic [AW:0]        count_q;
   logic [AW-1:0]      wr_ptr_p1;
   logic               pop_ok;

   assign wr_ptr_p1 = wr_ptr_q + 1'b1;
   assign pop_ok    = pop_i && (count_q != '0);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_q + AW'(push_cnt_i);
         rd_ptr_q <= rd_ptr_q + AW'(pop_ok);
         count_q  <= count_q + (AW+1)'(push_cnt_i) - (AW+1)'(pop_ok);
      end
   end

   // NOTE: storage is deliberately not reset; occupancy alone decides what is
   // valid, and leaving the array reset-free lets it map onto plain RAM/flops.
   always_ff @(posedge clk) begin
      if (push_cnt_i != 2'd0) mem_q[wr_ptr_q]  <= push_data0_i;
      if (push_cnt_i == 2'd2) mem_q[wr_ptr_p1] <= push_data1_i;
   end

   assign out_valid_o = (count_q != '0);
   assign out_data_o  = mem_q[rd_ptr_q];
   assign free_o      = (AW+1)'(DEPTH) - count_q;

endmodule

// File: rtl/mystery_stream_decoder.sv
// Mystery2 receive decoder: follows the scrambler phase, flags broken
// transforms and extracts seed/A/B bytes into a tagged byte FIFO.
module mystery_stream_decoder
   import mystery_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int ERR_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_word,
   input  logic             in_sync,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_byte,
   output logic [1:0]       out_tag,
   output logic             locked,
   output logic             err_pulse,
   output logic [ERR_W-1:0] err_count
);

   localparam int AW = $clog2(DEPTH);

   dec_state_e         state_q, state_d;
   logic [15:0]        p_q, p_d;
   logic [1:0]         phase_q, phase_d;
   logic               err_pulse_q, err_pulse_d;
   logic [ERR_W-1:0]   err_count_q, err_count_d;

   logic               accept;
   logic               check_ok;
   logic [1:0]         push_cnt;
   logic [ENTRY_W-1:0] push_data0;
   logic [ENTRY_W-1:0] push_data1;
   logic [ENTRY_W-1:0] fifo_data;
   logic [AW:0]        free;

   // Readiness depends only on registered occupancy, never on out_ready.
   assign in_ready = (free >= (AW+1)'(2));
   assign accept   = in_valid && in_ready;

   always_comb begin
      check_ok = 1'b0;
      unique case (phase_q)
         2'd0: check_ok = (in_word == swap_bytes(p_q));
         2'd1: check_ok = (in_word[15:8] == p_q[7:0]);
         2'd2: check_ok = (in_word[7:0] == p_q[15:8]);
         2'd3: check_ok = (in_word == nibble_rev(p_q));
         default: check_ok = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= HUNT;
         p_q         <= '0;
         phase_q     <= '0;
         err_pulse_q <= 1'b0;
         err_count_q <= '0;
      end else begin
         state_q     <= state_d;
         p_q         <= p_d;
         phase_q     <= phase_d;
         err_pulse_q <= err_pulse_d;
         err_count_q <= err_count_d;
      end
   end

   // NOTE: every combinational output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_d     = state_q;
      p_d         = p_q;
      phase_d     = phase_q;
      err_count_d = err_count_q;
      if (accept) begin
         if (in_sync) begin
            state_d = TRACK;
            p_d     = in_word;
            phase_d = 2'd0;
         end else if (state_q == TRACK) begin
            if (check_ok) begin
               p_d     = in_word;
               phase_d = phase_q + 2'd1;
            end else begin
               state_d = HUNT;
               phase_d = 2'd0;
               if (err_count_q != '1) err_count_d = err_count_q + 1'b1;
            end
         end
      end
   end

   always_comb begin
      push_cnt    = 2'd0;
      push_data0  = '0;
      push_data1  = '0;
      err_pulse_d = 1'b0;
      if (accept) begin
         if (in_sync) begin
            push_cnt   = 2'd2;
            push_data0 = {SEED_HI, in_word[15:8]};
            push_data1 = {SEED_LO, in_word[7:0]};
         end else if (state_q == TRACK) begin
            if (!check_ok) begin
               err_pulse_d = 1'b1;
            end else if (phase_q == 2'd1) begin
               push_cnt   = 2'd1;
               push_data0 = {BYTE_A, in_word[7:0]};
            end else if (phase_q == 2'd2) begin
               push_cnt   = 2'd1;
               push_data0 = {BYTE_B, in_word[15:8]};
            end
         end
      end
   end

   mystery_byte_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk          (clk),
      .reset        (reset),
      .push_cnt_i   (push_cnt),
      .push_data0_i (push_data0),
      .push_data1_i (push_data1),
      .pop_i        (out_valid && out_ready),
      .out_valid_o  (out_valid),
      .out_data_o   (fifo_data),
      .free_o       (free)
   );

   assign out_byte  = fifo_data[7:0];
   assign out_tag   = fifo_data[9:8];
   assign locked    = (state_q == TRACK);
   assign err_pulse = err_pulse_q;
   assign err_count = err_count_q;

endmodule

// File: doc/mystery_stream_decoder.md
Name: mystery_stream_decoder

Overview:
Receive-side decoder for the 16-bit Mystery2 scrambled word stream. It tracks the scrambler's 4-phase counter and checks every deterministic word transformation. It extracts the injected seed, A and B bytes into a byte FIFO with a valid/ready output. It sits downstream of the scrambler output (or its link) and feeds byte consumers and error monitoring.

Parameters:
DEPTH, 4, output FIFO entries (power of 2, >= 2)
ERR_W, 8, width of saturating error counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  in_word/in_sync valid this cycle
in_ready  output  1  decoder accepts word this cycle
in_word  input  16  one scrambler output word per accepted beat
in_sync  input  1  word is the scrambler's reset-load word (seed)
out_valid  output  1  out_byte/out_tag valid
out_ready  input  1  consumer accepts byte
out_byte  output  8  extracted byte
out_tag  output  2  0=SEED_HI, 1=SEED_LO, 2=BYTE_A, 3=BYTE_B
locked  output  1  decoder in TRACK state
err_pulse  output  1  one-cycle pulse on check mismatch
err_count  output  ERR_W  saturating mismatch count

Behaviour:
- Accept = in_valid && in_ready.
- in_ready = 1 when FIFO free slots >= 2, independent of in_valid.
- State: HUNT (reset state) and TRACK. Registers: prev word P[15:0], phase[1:0].
- Reset values: state=HUNT, P=0, phase=0, FIFO empty, out_valid=0, locked=0, err_pulse=0, err_count=0.
- Accept with in_sync=1, any state: P<=W; phase<=0; state<=TRACK.
  - Push W[15:8] tag SEED_HI, then W[7:0] tag SEED_LO (two FIFO writes in one cycle).
  - No check is performed.
- HUNT, accept without sync: word dropped; no push, no error.
- TRACK, accept without sync, checked against P by phase:
  - phase 0: expect W == {P[7:0],P[15:8]}.
  - phase 1: expect W[15:8] == P[7:0]; push W[7:0] tag BYTE_A.
  - phase 2: expect W[7:0] == P[15:8]; push W[15:8] tag BYTE_B.
  - phase 3: expect W == {P[3:0],P[7:4],P[11:8],P[15:12]}.
  - On pass: P<=W; phase<=phase+1, wrapping 3->0.
  - On mismatch: no push; err_pulse=1 on the next cycle; err_count+1, saturating at all-ones; state<=HUNT; phase<=0.
- Checks and pushes are registered: a pushed byte appears at out_valid one cycle after accept at the earliest.
- FIFO: first-word fall-through. Pop = out_valid && out_ready. Simultaneous push and pop in the same cycle are legal; occupancy = old + pushes - pops.
- FIFO full: in_ready is already 0 when fewer than 2 slots are free, so there is never overflow.
- FIFO empty: out_valid=0; out_byte/out_tag don't-care.
- Reset mid-operation: flushes the FIFO, clears err_count, returns to HUNT within the same clock edge.
- No combinational path from out_ready to in_ready other than through registered FIFO occupancy.

Decomposition:
- Package mystery_pkg:
  - tag_e (SEED_HI, SEED_LO, BYTE_A, BYTE_B)
  - dec_state_e (HUNT, TRACK)
  - functions swap_bytes(w) and nibble_rev(w), shared with the scrambler.
- Sub-module mystery_byte_fifo: DEPTH x 10-bit sync FIFO with 0/1/2 pushes per cycle, 1 pop, and a free-count output.

Test Plan:
- Sync 0x1234, then 0x3412, 0x12AB, 0xCD12, 0x21DC, 0xDC21, out_ready=1:
  - bytes (0x12,SEED_HI), (0x34,SEED_LO), (0xAB,BYTE_A), (0xCD,BYTE_B) in order
  - locked=1, err_count=0.
- Sync 0x1234, then 0x3413 (bad swap):
  - err_pulse for one cycle; err_count=1; locked=0.
  - A following 0x12AB is dropped.
- Words before any sync:
  - no output, no error.
  - Then sync 0xBEEF yields 0xBE, 0xEF.
- out_ready=0 with DEPTH=4 after sync 0x1234 + 0x3412 + 0x12AB:
  - 3 entries held; in_ready=0 (1 free slot) until a pop.
  - Ordering preserved after out_ready=1.
- ERR_W=2, five mismatch/resync cycles:
  - err_count saturates at 3.
- Reset asserted while FIFO holds 2 bytes and in TRACK:
  - next cycle out_valid=0, locked=0, err_count=0.
  - The following sync behaves as in the first scenario.
